// File: rtl/uart_pkg.sv
// Shared constants, state encoding and baud-to-divider mapping for the UART transmit path.
package uart_pkg;

   localparam logic [1:0] BAUD_2400  = 2'b00;
   localparam logic [1:0] BAUD_4800  = 2'b01;
   localparam logic [1:0] BAUD_9600  = 2'b10;
   localparam logic [1:0] BAUD_19200 = 2'b11;

   // Bit periods in 50 MHz clock cycles
   localparam logic [14:0] DIV_2400  = 15'd20833;
   localparam logic [14:0] DIV_4800  = 15'd10417;
   localparam logic [14:0] DIV_9600  = 15'd5208;
   localparam logic [14:0] DIV_19200 = 15'd2604;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic logic [14:0] baudDiv(input logic [1:0] sel);
      logic [14:0] div;
      case (sel)
         BAUD_2400:  div = DIV_2400;
         BAUD_4800:  div = DIV_4800;
         BAUD_9600:  div = DIV_9600;
         default:    div = DIV_19200;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake, frame format and serial line signals between a byte source and the transmitter.
interface uart_tx_ctrl_if;

   logic [1:0] baud_sel;
   logic       parity_en;
   logic       parity_odd;
   logic       stop2;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_out;
   logic       busy;
   logic       frame_done;

   modport master (
      output baud_sel, parity_en, parity_odd, stop2, tx_data, tx_valid,
      input  tx_ready, tx_out, busy, frame_done
   );

   modport slave (
      input  baud_sel, parity_en, parity_odd, stop2, tx_data, tx_valid,
      output tx_ready, tx_out, busy, frame_done
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Restartable bit-period counter: ticks on the last cycle of every div-cycle period.
module uart_bit_timer (
   input  logic        clock,
   input  logic        rst,
   input  logic        restart,
   input  logic [14:0] div,
   output logic        bit_tick
);

   logic [14:0] count_q;
   logic [14:0] count_d;

   assign bit_tick = !restart && (count_q == (div - 15'd1));

   // Held at zero while restart is high so the first period starts on acceptance
   always_comb begin
      count_d = count_q + 15'd1;
      if (restart || bit_tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: latches a byte and its format at acceptance, then walks
// start, data, optional parity and stop bits, each lasting one bit-timer period.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_OVERRIDE = 0
) (
   input logic           clock,
   input logic           rst,
   uart_tx_ctrl_if.slave bus
);

   localparam logic [14:0] DIV_OVR = 15'(DIV_OVERRIDE);

   tx_state_t   state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic [14:0] div_q, div_d;
   logic        parEn_q, parEn_d;
   logic        parOdd_q, parOdd_d;
   logic        stop2_q, stop2_d;
   logic        stopCnt_q, stopCnt_d;
   logic        txOut_q, txOut_d;
   logic        frameDone_q, frameDone_d;
   logic        bitTick;
   logic        accept;
   logic        lastStop;

   assign bus.tx_ready   = (state_q == IDLE) && !rst;
   assign bus.busy       = (state_q != IDLE);
   assign bus.tx_out     = txOut_q;
   assign bus.frame_done = frameDone_q;

   assign accept   = bus.tx_valid && bus.tx_ready;
   assign lastStop = !(stop2_q && !stopCnt_q);

   uart_bit_timer bitTimer (
      .clock    (clock),
      .rst      (rst),
      .restart  (state_q == IDLE),
      .div      (div_q),
      .bit_tick (bitTick)
   );

   // State and frame register
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         data_q      <= '0;
         div_q       <= DIV_19200;
         parEn_q     <= 1'b0;
         parOdd_q    <= 1'b0;
         stop2_q     <= 1'b0;
         stopCnt_q   <= 1'b0;
         txOut_q     <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         div_q       <= div_d;
         parEn_q     <= parEn_d;
         parOdd_q    <= parOdd_d;
         stop2_q     <= stop2_d;
         stopCnt_q   <= stopCnt_d;
         txOut_q     <= txOut_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Next state; the frame format is captured only on acceptance
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      div_d     = div_q;
      parEn_d   = parEn_q;
      parOdd_d  = parOdd_q;
      stop2_d   = stop2_q;
      stopCnt_d = stopCnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               data_d    = bus.tx_data;
               div_d     = (DIV_OVR != 15'd0) ? DIV_OVR : baudDiv(bus.baud_sel);
               parEn_d   = bus.parity_en;
               parOdd_d  = bus.parity_odd;
               stop2_d   = bus.stop2;
               idx_d     = '0;
               stopCnt_d = 1'b0;
            end
         end
         START: begin
            if (bitTick) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bitTick) begin
               if (idx_q == 3'd7) begin
                  state_d   = parEn_q ? PARITY : STOP;
                  stopCnt_d = 1'b0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bitTick) begin
               state_d   = STOP;
               stopCnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bitTick) begin
               if (lastStop) begin
                  state_d = IDLE;
               end else begin
                  stopCnt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so tx_out leaves a flop
   always_comb begin
      frameDone_d = (state_q == STOP) && bitTick && lastStop;
      case (state_d)
         START:   txOut_d = 1'b0;
         DATA:    txOut_d = data_d[idx_d];
         PARITY:  txOut_d = (^data_d) ^ parOdd_d;
         default: txOut_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model for a fast
// (DIV_OVERRIDE=4) instance plus directed timing of a real-baud instance.
module tb_uart_tx_ctrl;

   localparam int FDIV = 4;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   uart_tx_ctrl_if fIf ();
   uart_tx_ctrl_if sIf ();

   uart_tx_ctrl #(.DIV_OVERRIDE(FDIV)) dutFast (
      .clock (clock),
      .rst   (rst),
      .bus   (fIf)
   );

   uart_tx_ctrl #(.DIV_OVERRIDE(0)) dutSlow (
      .clock (clock),
      .rst   (rst),
      .bus   (sIf)
   );

   // Reference model: an accepted byte becomes a list of line levels, each held FDIV cycles
   bit   mActive = 1'b0;
   bit   mFd     = 1'b0;
   int   mK      = 0;
   int   mLen    = 0;
   logic mBits [12];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s timed out at %0t", name, $time);
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge rst);
         if (rst) begin
            mActive = 1'b0;
            mFd     = 1'b0;
         end else begin
            mFd = 1'b0;
            if (mActive) begin
               mK++;
               if (mK == mLen) begin
                  mActive = 1'b0;
                  mFd     = 1'b1;
               end
            end else if (fIf.tx_valid === 1'b1) begin
               int n;
               logic [7:0] d;
               d = fIf.tx_data;
               mBits[0] = 1'b0;
               for (int i = 0; i < 8; i++) mBits[i + 1] = d[i];
               n = 9;
               if (fIf.parity_en) begin
                  mBits[n] = (^d) ^ fIf.parity_odd;
                  n++;
               end
               mBits[n] = 1'b1;
               n++;
               if (fIf.stop2) begin
                  mBits[n] = 1'b1;
                  n++;
               end
               mLen    = n * FDIV;
               mK      = 0;
               mActive = 1'b1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the fast instance against the model
   initial begin
      forever begin
         @(negedge clock);
         checkOutput("m_tx_out", 32'(fIf.tx_out), mActive ? 32'(mBits[mK / FDIV]) : 32'd1);
         checkOutput("m_busy", 32'(fIf.busy), 32'(mActive));
         checkOutput("m_tx_ready", 32'(fIf.tx_ready), 32'(!mActive && !rst));
         checkOutput("m_frame_done", 32'(fIf.frame_done), 32'(mFd));
      end
   end

   task automatic waitReady(input string name);
      int n = 0;
      while (fIf.tx_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clock);
      end
      if (n >= 200) timeoutFail(name);
   endtask

   // Send one byte and pin its bit levels and frame length to hand-derived literals
   task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parOdd,
                                input logic st2, input logic [11:0] expBits, input int nBits,
                                input int expLen, input string name);
      int fdAt = -1;
      @(negedge clock);
      fIf.tx_data    = data;
      fIf.parity_en  = parEn;
      fIf.parity_odd = parOdd;
      fIf.stop2      = st2;
      fIf.baud_sel   = 2'($urandom);
      fIf.tx_valid   = 1'b1;
      waitReady({name, "_accept"});
      @(negedge clock);
      fIf.tx_valid   = 1'b0;
      fIf.tx_data    = 8'($urandom);
      fIf.parity_en  = 1'($urandom);
      fIf.parity_odd = 1'($urandom);
      fIf.stop2      = 1'($urandom);
      for (int k = 0; k < expLen + 2; k++) begin
         if ((k % FDIV) == 1 && (k / FDIV) < nBits) begin
            checkOutput($sformatf("%s_bit%0d", name, k / FDIV), 32'(fIf.tx_out), 32'(expBits[k / FDIV]));
         end
         if (fIf.frame_done === 1'b1 && fdAt < 0) fdAt = k;
         @(negedge clock);
      end
      checkOutput({name, "_len"}, 32'(fdAt), 32'(expLen));
   endtask

   initial begin
      int cnt;
      fIf.tx_valid = 1'b0; fIf.tx_data = '0; fIf.baud_sel = '0;
      fIf.parity_en = 1'b0; fIf.parity_odd = 1'b0; fIf.stop2 = 1'b0;
      sIf.tx_valid = 1'b0; sIf.tx_data = '0; sIf.baud_sel = '0;
      sIf.parity_en = 1'b0; sIf.parity_odd = 1'b0; sIf.stop2 = 1'b0;

      repeat (3) @(negedge clock);
      #1;
      checkOutput("rst_tx_out", 32'(fIf.tx_out), 32'd1);
      checkOutput("rst_busy", 32'(fIf.busy), 32'd0);
      checkOutput("rst_ready", 32'(fIf.tx_ready), 32'd0);
      checkOutput("rst_frame_done", 32'(fIf.frame_done), 32'd0);
      @(negedge clock);
      #2 rst = 1'b0;

      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 40, "a5");
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b0, 12'h406, 11, 44, "par_even");
      applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 12'h606, 11, 44, "par_odd");
      applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 12'hE06, 12, 48, "stop2");

      // tx_valid held across two frames
      @(negedge clock);
      fIf.tx_data = 8'h55; fIf.parity_en = 1'b0; fIf.stop2 = 1'b0; fIf.tx_valid = 1'b1;
      waitReady("b2b_accept");
      @(negedge clock);
      fIf.tx_data = 8'h0F;
      cnt = 0;
      while (fIf.frame_done !== 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clock);
      end
      checkOutput("b2b_len", 32'(cnt), 32'd40);
      checkOutput("b2b_gap_tx", 32'(fIf.tx_out), 32'd1);
      checkOutput("b2b_gap_ready", 32'(fIf.tx_ready), 32'd1);
      @(negedge clock);
      checkOutput("b2b_second_busy", 32'(fIf.busy), 32'd1);
      checkOutput("b2b_second_start", 32'(fIf.tx_out), 32'd0);
      fIf.tx_valid = 1'b0;
      repeat (45) @(negedge clock);

      // Reset during data bit 3 (a zero bit of 0xC3)
      fIf.tx_data = 8'hC3; fIf.parity_en = 1'b0; fIf.stop2 = 1'b0; fIf.tx_valid = 1'b1;
      waitReady("rst_accept");
      @(negedge clock);
      fIf.tx_valid = 1'b0;
      repeat (17) @(negedge clock);
      checkOutput("pre_rst_tx", 32'(fIf.tx_out), 32'd0);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_tx_out", 32'(fIf.tx_out), 32'd1);
      checkOutput("midrst_busy", 32'(fIf.busy), 32'd0);
      checkOutput("midrst_ready", 32'(fIf.tx_ready), 32'd0);
      repeat (2) @(negedge clock);
      #2 rst = 1'b0;
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 40, "after_rst");

      // Random traffic; format inputs wander freely mid-frame
      repeat (800) begin
         @(negedge clock);
         fIf.tx_valid   = ($urandom_range(0, 3) == 0);
         fIf.tx_data    = 8'($urandom);
         fIf.baud_sel   = 2'($urandom);
         fIf.parity_en  = 1'($urandom);
         fIf.parity_odd = 1'($urandom);
         fIf.stop2      = 1'($urandom);
      end
      @(negedge clock);
      fIf.tx_valid = 1'b0;
      repeat (60) @(negedge clock);

      // Real baud divider: 0x55 toggles on every bit so each run is one bit period
      sIf.tx_data = 8'h55; sIf.baud_sel = 2'b11; sIf.tx_valid = 1'b1;
      cnt = 0;
      while (sIf.tx_ready !== 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clock);
      end
      if (cnt >= 200) timeoutFail("slow_accept");
      @(negedge clock);
      sIf.tx_valid = 1'b0;
      for (int s = 0; s < 9; s++) begin
         cnt = 0;
         while (sIf.tx_out == (s % 2 == 1) && cnt < 3000) begin
            cnt++;
            @(negedge clock);
         end
         checkOutput($sformatf("slow_bit%0d", s), 32'(cnt), 32'd2604);
         if (s == 0) sIf.baud_sel = 2'b00;
      end
      cnt = 0;
      while (sIf.frame_done !== 1'b1 && cnt < 3000) begin
         cnt++;
         @(negedge clock);
      end
      checkOutput("slow_stop", 32'(cnt), 32'd2604);
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
